// File: rtl/init_mac_seq.sv
// init_mac_seq: table-driven Avalon-MM master that brings a MAC up after reset.
// Walks a parametrised command list (WRITE / POLL / DELAY / END). Bus accesses and
// polls are guarded by timeouts. mac_inited gates the downstream datapath.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset, waits for AUTO_START or start
// FETCH   | latch entry idx, clear counters, dispatch on opcode
// WRITE   | WR asserted, held until BUSY low or bus timeout
// READ    | RD asserted, held until BUSY low or bus timeout, captures DAT_I
// CMP     | masked compare of read data, retry or advance
// DELAY   | down-count the entry data value
// DONE    | sequence complete, mac_inited high
// ERR     | sequence aborted, error/err_idx/err_code valid
module init_mac_seq #(
    parameter int                         ADDR_W       = 10,
    parameter int                         DATA_W       = 32,
    parameter int                         N_CMD        = 8,
    parameter logic [2*N_CMD-1:0]         CMD_OP       = '0,
    parameter logic [ADDR_W*N_CMD-1:0]    CMD_ADDR     = '0,
    parameter logic [DATA_W*N_CMD-1:0]    CMD_DATA     = '0,
    parameter logic [DATA_W*N_CMD-1:0]    CMD_MASK     = '1,
    parameter int                         POLL_TIMEOUT = 1000,
    parameter int                         BUS_TIMEOUT  = 255,
    parameter bit                         AUTO_START   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] ADR_O,
    input  logic [DATA_W-1:0] DAT_I,
    output logic [DATA_W-1:0] DAT_O,
    output logic              RD,
    output logic              WR,
    input  logic              BUSY,
    input  logic              start,
    output logic              seq_busy,
    output logic              mac_inited,
    output logic              error,
    output logic [7:0]        err_idx,
    output logic [1:0]        err_code
);

    localparam int IDX_W  = $clog2(N_CMD + 1);
    localparam int BUS_W  = (BUS_TIMEOUT  < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam int POLL_W = (POLL_TIMEOUT < 1) ? 1 : $clog2(POLL_TIMEOUT + 1);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_POLL  = 2'd1;
    localparam logic [1:0] OP_DELAY = 2'd2;
    localparam logic [1:0] OP_END   = 2'd3;

    localparam logic [1:0] ERR_POLL = 2'd1;
    localparam logic [1:0] ERR_BUS  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_READ,
        S_CMP,
        S_DELAY,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [IDX_W-1:0]    r_idx,        w_idx_nxt;
    logic [ADDR_W-1:0]   r_addr,       w_addr_nxt;
    logic [DATA_W-1:0]   r_data,       w_data_nxt;
    logic [DATA_W-1:0]   r_mask,       w_mask_nxt;
    logic [DATA_W-1:0]   r_rdata,      w_rdata_nxt;
    logic [DATA_W-1:0]   r_dly_cnt,    w_dly_cnt_nxt;
    logic [BUS_W-1:0]    r_bus_cnt,    w_bus_cnt_nxt;
    logic [POLL_W-1:0]   r_poll_cnt,   w_poll_cnt_nxt;
    logic                r_rd,         w_rd_nxt;
    logic                r_wr,         w_wr_nxt;
    logic                r_seq_busy,   w_seq_busy_nxt;
    logic                r_mac_inited, w_mac_inited_nxt;
    logic                r_error,      w_error_nxt;
    logic [7:0]          r_err_idx,    w_err_idx_nxt;
    logic [1:0]          r_err_code,   w_err_code_nxt;

    logic [1:0]          w_tab_op;
    logic [ADDR_W-1:0]   w_tab_addr;
    logic [DATA_W-1:0]   w_tab_data;
    logic [DATA_W-1:0]   w_tab_mask;
    logic                w_last;
    logic                w_match;

    // Select the table entry addressed by idx; past the end reads back as END.
    always_comb begin
        w_tab_op   = OP_END;
        w_tab_addr = '0;
        w_tab_data = '0;
        w_tab_mask = '0;
        for (int i = 0; i < N_CMD; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_tab_op   = CMD_OP[2*i +: 2];
                w_tab_addr = CMD_ADDR[ADDR_W*i +: ADDR_W];
                w_tab_data = CMD_DATA[DATA_W*i +: DATA_W];
                w_tab_mask = CMD_MASK[DATA_W*i +: DATA_W];
            end
        end
    end

    // Finishing the last table entry goes straight to DONE, skipping an
    // end-of-table FETCH cycle.
    assign w_last  = (r_idx == IDX_W'(N_CMD - 1));
    assign w_match = ((r_rdata & r_mask) == (r_data & r_mask));

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_mask_nxt       = r_mask;
        w_rdata_nxt      = r_rdata;
        w_dly_cnt_nxt    = r_dly_cnt;
        w_bus_cnt_nxt    = r_bus_cnt;
        w_poll_cnt_nxt   = r_poll_cnt;
        w_err_idx_nxt    = r_err_idx;
        w_err_code_nxt   = r_err_code;

        case (r_state)
            S_IDLE: begin
                if (AUTO_START || start) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = '0;
                end
            end

            S_FETCH: begin
                w_addr_nxt     = w_tab_addr;
                w_data_nxt     = w_tab_data;
                w_mask_nxt     = w_tab_mask;
                w_dly_cnt_nxt  = w_tab_data;
                w_bus_cnt_nxt  = BUS_W'(BUS_TIMEOUT);
                w_poll_cnt_nxt = POLL_W'(POLL_TIMEOUT);
                if (r_idx == IDX_W'(N_CMD)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    case (w_tab_op)
                        OP_WRITE: w_state_nxt = S_WRITE;
                        OP_POLL:  w_state_nxt = S_READ;
                        OP_DELAY: w_state_nxt = S_DELAY;
                        default:  w_state_nxt = S_DONE;
                    endcase
                end
            end

            S_WRITE, S_READ: begin
                if (!BUSY) begin
                    if (r_state == S_READ) begin
                        w_rdata_nxt = DAT_I;
                        w_state_nxt = S_CMP;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = w_last ? S_DONE : S_FETCH;
                    end
                end else if (r_bus_cnt <= BUS_W'(1)) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_BUS;
                    w_err_idx_nxt  = 8'(r_idx);
                end else begin
                    w_bus_cnt_nxt = r_bus_cnt - BUS_W'(1);
                end
            end

            S_CMP: begin
                if (w_match) begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = w_last ? S_DONE : S_FETCH;
                end else if (r_poll_cnt <= POLL_W'(1)) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_POLL;
                    w_err_idx_nxt  = 8'(r_idx);
                end else begin
                    w_poll_cnt_nxt = r_poll_cnt - POLL_W'(1);
                    w_bus_cnt_nxt  = BUS_W'(BUS_TIMEOUT);
                    w_state_nxt    = S_READ;
                end
            end

            // A loaded count of 0 or 1 both finish after a single cycle here.
            S_DELAY: begin
                if (r_dly_cnt <= DATA_W'(1)) begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = w_last ? S_DONE : S_FETCH;
                end else begin
                    w_dly_cnt_nxt = r_dly_cnt - DATA_W'(1);
                end
            end

            S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt    = S_FETCH;
                    w_idx_nxt      = '0;
                    w_err_idx_nxt  = '0;
                    w_err_code_nxt = '0;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase

        w_rd_nxt         = (w_state_nxt == S_READ);
        w_wr_nxt         = (w_state_nxt == S_WRITE);
        w_seq_busy_nxt   = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) &&
                           (w_state_nxt != S_ERR);
        w_mac_inited_nxt = (w_state_nxt == S_DONE);
        w_error_nxt      = (w_state_nxt == S_ERR);
    end

    // State, datapath and output registers; reset drops RD/WR immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_mask       <= '0;
            r_rdata      <= '0;
            r_dly_cnt    <= '0;
            r_bus_cnt    <= '0;
            r_poll_cnt   <= '0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_seq_busy   <= 1'b0;
            r_mac_inited <= 1'b0;
            r_error      <= 1'b0;
            r_err_idx    <= '0;
            r_err_code   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_mask       <= w_mask_nxt;
            r_rdata      <= w_rdata_nxt;
            r_dly_cnt    <= w_dly_cnt_nxt;
            r_bus_cnt    <= w_bus_cnt_nxt;
            r_poll_cnt   <= w_poll_cnt_nxt;
            r_rd         <= w_rd_nxt;
            r_wr         <= w_wr_nxt;
            r_seq_busy   <= w_seq_busy_nxt;
            r_mac_inited <= w_mac_inited_nxt;
            r_error      <= w_error_nxt;
            r_err_idx    <= w_err_idx_nxt;
            r_err_code   <= w_err_code_nxt;
        end
    end

    assign ADR_O      = r_addr;
    assign DAT_O      = r_data;
    assign RD         = r_rd;
    assign WR         = r_wr;
    assign seq_busy   = r_seq_busy;
    assign mac_inited = r_mac_inited;
    assign error      = r_error;
    assign err_idx    = r_err_idx;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_init_mac_seq.sv
// Bench for init_mac_seq: four instances with different command tables
// (writes, polls, bus timeout, delay/END), all sharing one clock.
module tb_init_mac_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    logic rst_n = 1'b0;
    logic a_rst = 1'b0;

    // ---------------- instance A: three writes, auto start ----------------
    logic [9:0]  a_adr;
    logic [31:0] a_dat_o;
    logic [31:0] a_dat_i = 32'h0;
    logic        a_rd, a_wr, a_sb, a_mi, a_er;
    logic        a_busy = 1'b0, a_start = 1'b0;
    logic [7:0]  a_eidx;
    logic [1:0]  a_ecode;

    init_mac_seq #(
        .ADDR_W(10), .DATA_W(32), .N_CMD(3),
        .CMD_OP(6'b00_00_00),
        .CMD_ADDR({10'h002, 10'h00E, 10'h008}),
        .CMD_DATA({32'hAABB_CCDD, 32'h0000_0010, 32'h0000_0003}),
        .AUTO_START(1'b1)
    ) u_a (
        .clk(clk), .reset_n(a_rst), .ADR_O(a_adr), .DAT_I(a_dat_i), .DAT_O(a_dat_o),
        .RD(a_rd), .WR(a_wr), .BUSY(a_busy), .start(a_start), .seq_busy(a_sb),
        .mac_inited(a_mi), .error(a_er), .err_idx(a_eidx), .err_code(a_ecode)
    );

    // ---------------- instance P: write, two polls, write ----------------
    logic [9:0]  p_adr;
    logic [31:0] p_dat_o, p_dat_i;
    logic        p_rd, p_wr, p_sb, p_mi, p_er;
    logic        p_busy = 1'b0, p_start = 1'b0;
    logic [7:0]  p_eidx;
    logic [1:0]  p_ecode;

    init_mac_seq #(
        .ADDR_W(10), .DATA_W(32), .N_CMD(4),
        .CMD_OP({2'd0, 2'd1, 2'd1, 2'd0}),
        .CMD_ADDR({10'h020, 10'h006, 10'h004, 10'h010}),
        .CMD_DATA({32'h0000_0077, 32'h0000_00A0, 32'h0000_0001, 32'h0000_0005}),
        .CMD_MASK({32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_0001, 32'hFFFF_FFFF}),
        .POLL_TIMEOUT(5), .AUTO_START(1'b0)
    ) u_p (
        .clk(clk), .reset_n(rst_n), .ADR_O(p_adr), .DAT_I(p_dat_i), .DAT_O(p_dat_o),
        .RD(p_rd), .WR(p_wr), .BUSY(p_busy), .start(p_start), .seq_busy(p_sb),
        .mac_inited(p_mi), .error(p_er), .err_idx(p_eidx), .err_code(p_ecode)
    );

    // ---------------- instance B: write then poll, bus timeout 10 ----------------
    logic [9:0]  b_adr;
    logic [31:0] b_dat_o;
    logic [31:0] b_dat_i = 32'h0000_0005;
    logic        b_rd, b_wr, b_sb, b_mi, b_er;
    logic        b_busy = 1'b0, b_start = 1'b0;
    logic [7:0]  b_eidx;
    logic [1:0]  b_ecode;

    init_mac_seq #(
        .ADDR_W(10), .DATA_W(32), .N_CMD(2),
        .CMD_OP({2'd1, 2'd0}),
        .CMD_ADDR({10'h002, 10'h001}),
        .CMD_DATA({32'h0000_0005, 32'h0000_0011}),
        .CMD_MASK({32'h0000_000F, 32'hFFFF_FFFF}),
        .BUS_TIMEOUT(10), .AUTO_START(1'b0)
    ) u_b (
        .clk(clk), .reset_n(rst_n), .ADR_O(b_adr), .DAT_I(b_dat_i), .DAT_O(b_dat_o),
        .RD(b_rd), .WR(b_wr), .BUSY(b_busy), .start(b_start), .seq_busy(b_sb),
        .mac_inited(b_mi), .error(b_er), .err_idx(b_eidx), .err_code(b_ecode)
    );

    // ---------------- instance D: DELAY 0, WRITE, DELAY 20, END, WRITE ----------------
    logic [9:0]  d_adr;
    logic [31:0] d_dat_o;
    logic [31:0] d_dat_i = 32'h0;
    logic        d_rd, d_wr, d_sb, d_mi, d_er;
    logic        d_busy = 1'b0, d_start = 1'b0;
    logic [7:0]  d_eidx;
    logic [1:0]  d_ecode;

    init_mac_seq #(
        .ADDR_W(10), .DATA_W(32), .N_CMD(5),
        .CMD_OP({2'd0, 2'd3, 2'd2, 2'd0, 2'd2}),
        .CMD_ADDR({10'h3FF, 10'h000, 10'h000, 10'h0AA, 10'h000}),
        .CMD_DATA({32'h0000_DEAD, 32'h0, 32'd20, 32'h0000_0001, 32'h0}),
        .AUTO_START(1'b0)
    ) u_d (
        .clk(clk), .reset_n(rst_n), .ADR_O(d_adr), .DAT_I(d_dat_i), .DAT_O(d_dat_o),
        .RD(d_rd), .WR(d_wr), .BUSY(d_busy), .start(d_start), .seq_busy(d_sb),
        .mac_inited(d_mi), .error(d_er), .err_idx(d_eidx), .err_code(d_ecode)
    );

    // Slave model for P: read counts advance mid-cycle so DAT_I is stable at the capture edge.
    int p_rd004 = 0, p_rd006 = 0, p_wr020 = 0, n_overlap = 0;
    int p_base004 = 0;
    logic p_fail_mode = 1'b0;

    always @(negedge clk) begin
        if (p_rd && p_adr == 10'h004) p_rd004++;
        if (p_rd && p_adr == 10'h006) p_rd006++;
        if (p_wr && p_adr == 10'h020) p_wr020++;
        if ((a_rd && a_wr) || (p_rd && p_wr) || (b_rd && b_wr) || (d_rd && d_wr)) n_overlap++;
    end

    always_comb begin
        p_dat_i = 32'h0;
        if (p_adr == 10'h004)
            p_dat_i = p_fail_mode ? 32'h1 : (((p_rd004 - p_base004) >= 3) ? 32'h1 : 32'hFFFF_FFFE);
        else if (p_adr == 10'h006)
            p_dat_i = p_fail_mode ? 32'h0 : 32'h1234_56A5;
    end

    typedef struct {
        logic        busy;
        logic        start;
        logic        wr;
        logic [9:0]  adr;
        logic [31:0] dat;
        logic        sb;
        logic        mi;
    } vec_t;

    function automatic vec_t mk(input logic bz, input logic st, input logic wr,
                                input logic [9:0] ad, input logic [31:0] dt,
                                input logic sb, input logic mi);
        vec_t v;
        v.busy = bz; v.start = st; v.wr = wr; v.adr = ad; v.dat = dt; v.sb = sb; v.mi = mi;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[20];
        int   n, k, first_wr_k, mi_k, wr_cnt, bad_wr, b04, b06, bw20;
        logic seen, ok;
        logic [9:0]  wr_adr;
        logic [31:0] wr_dat;

        // After each edge: state check; busy/start drive the following edge.
        vecs[0]  = mk(0, 0, 0, 10'h000, 32'h0,          1, 0);
        vecs[1]  = mk(0, 0, 1, 10'h008, 32'h0000_0003, 1, 0);
        vecs[2]  = mk(0, 0, 0, 10'h000, 32'h0,          1, 0);
        vecs[3]  = mk(0, 0, 1, 10'h00E, 32'h0000_0010, 1, 0);
        vecs[4]  = mk(0, 0, 0, 10'h000, 32'h0,          1, 0);
        vecs[5]  = mk(0, 0, 1, 10'h002, 32'hAABB_CCDD, 1, 0);
        vecs[6]  = mk(0, 0, 0, 10'h000, 32'h0,          0, 1);
        vecs[7]  = mk(0, 1, 0, 10'h000, 32'h0,          0, 1);
        vecs[8]  = mk(0, 0, 0, 10'h000, 32'h0,          1, 0);
        vecs[9]  = mk(0, 0, 1, 10'h008, 32'h0000_0003, 1, 0);
        vecs[10] = mk(0, 0, 0, 10'h000, 32'h0,          1, 0);
        vecs[11] = mk(1, 0, 1, 10'h00E, 32'h0000_0010, 1, 0);
        vecs[12] = mk(1, 0, 1, 10'h00E, 32'h0000_0010, 1, 0);
        vecs[13] = mk(1, 1, 1, 10'h00E, 32'h0000_0010, 1, 0);
        vecs[14] = mk(1, 0, 1, 10'h00E, 32'h0000_0010, 1, 0);
        vecs[15] = mk(0, 0, 1, 10'h00E, 32'h0000_0010, 1, 0);
        vecs[16] = mk(0, 0, 0, 10'h000, 32'h0,          1, 0);
        vecs[17] = mk(0, 0, 1, 10'h002, 32'hAABB_CCDD, 1, 0);
        vecs[18] = mk(0, 0, 0, 10'h000, 32'h0,          0, 1);
        vecs[19] = mk(0, 0, 0, 10'h000, 32'h0,          0, 1);

        // Reset state
        #22;
        check("rst_a_outputs", {a_adr, a_dat_o, a_rd, a_wr, a_sb, a_mi, a_er, a_eidx, a_ecode}, 64'h0);
        check("rst_p_outputs", {p_adr, p_dat_o, p_rd, p_wr, p_sb, p_mi, p_er, p_eidx, p_ecode}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a_rst = 1'b1;

        // Table-driven write timing on A (no wait states, then 4 wait states)
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {a_wr, a_rd, a_sb, a_mi, a_er,
                   (vecs[i].wr ? a_adr : 10'h0), (vecs[i].wr ? a_dat_o : 32'h0)},
                  {vecs[i].wr, 1'b0, vecs[i].sb, vecs[i].mi, 1'b0, vecs[i].adr, vecs[i].dat});
            a_busy  = vecs[i].busy;
            a_start = vecs[i].start;
        end
        check("p_no_autostart", {p_sb, p_rd, p_wr, p_mi}, 4'h0);

        // Reset asserted in the middle of a WR cycle
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (a_wr) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("a_wr_before_reset", seen, 1'b1);
        #2 a_rst = 1'b0;
        #1 check("a_async_wr_drop", {a_wr, a_sb}, 2'b00);
        @(negedge clk) a_rst = 1'b1;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a_wr) begin n = c; break; end
        end
        check("a_rerun_first_wr_cycle", n, 2);
        check("a_rerun_first_wr_addr", {a_adr, a_dat_o}, {10'h008, 32'h0000_0003});

        // Poll success: 0x004 answers FFFFFFFE twice then 1; 0x006 matches under mask
        p_fail_mode = 1'b0;
        p_base004 = p_rd004; b04 = p_rd004; b06 = p_rd006; bw20 = p_wr020;
        @(negedge clk) p_start = 1'b1;
        @(negedge clk) p_start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!p_sb) begin ok = 1'b1; break; end
        end
        check("p_run1_finished", ok, 1'b1);
        check("p_run1_reads004", p_rd004 - b04, 3);
        check("p_run1_reads006", p_rd006 - b06, 1);
        check("p_run1_write020", p_wr020 - bw20, 1);
        check("p_run1_status", {p_mi, p_er, p_ecode}, 4'b1000);

        // Poll timeout at entry 2
        p_fail_mode = 1'b1;
        p_base004 = p_rd004; b04 = p_rd004; b06 = p_rd006; bw20 = p_wr020;
        @(negedge clk) p_start = 1'b1;
        @(negedge clk) p_start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!p_sb) begin ok = 1'b1; break; end
        end
        check("p_run2_finished", ok, 1'b1);
        check("p_run2_reads004", p_rd004 - b04, 1);
        check("p_run2_reads006", p_rd006 - b06, 5);
        check("p_run2_no_write020", p_wr020 - bw20, 0);
        check("p_run2_err", {p_er, p_mi, p_rd, p_wr}, 4'b1000);
        check("p_run2_err_idx", p_eidx, 8'd2);
        check("p_run2_err_code", p_ecode, 2'd1);

        // Restart from ERR clears the error report
        p_fail_mode = 1'b0;
        p_base004 = p_rd004;
        @(negedge clk) p_start = 1'b1;
        @(negedge clk) p_start = 1'b0;
        check("p_run3_restart_clears", {p_sb, p_er, p_eidx, p_ecode}, {1'b1, 1'b0, 8'd0, 2'd0});
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!p_sb) begin ok = 1'b1; break; end
        end
        check("p_run3_status", {ok, p_mi, p_er}, 3'b110);

        // Bus timeout: BUSY stuck high on entry 0
        b_busy = 1'b1;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        n = 0; ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (b_wr) n++;
            if (b_er) begin ok = 1'b1; break; end
        end
        check("b_timeout_seen", ok, 1'b1);
        check("b_timeout_wr_cycles", n, 10);
        check("b_timeout_status", {b_wr, b_rd, b_mi, b_sb, b_eidx, b_ecode}, {4'b0000, 8'd0, 2'd2});

        // Release BUSY and restart
        b_busy = 1'b0;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!b_sb) begin ok = 1'b1; break; end
        end
        check("b_restart_done", {ok, b_mi, b_er, b_ecode}, 5'b11000);

        // Nine BUSY-high cycles stay just inside the timeout
        b_busy = 1'b1;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        n = 0; ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (b_wr) begin
                n++;
                if (n == 10) b_busy = 1'b0;
            end
            if (!b_sb) begin ok = 1'b1; break; end
        end
        check("b_edge_wr_cycles", n, 10);
        check("b_edge_done", {ok, b_mi, b_er}, 3'b110);

        // DELAY 0, WRITE, DELAY 20, END; entry 4 must never be accessed
        first_wr_k = -1; mi_k = -1; wr_cnt = 0; bad_wr = 0; wr_adr = '0; wr_dat = '0;
        @(negedge clk) d_start = 1'b1;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) begin
                d_start = 1'b0;
                check("d_busy_after_start", d_sb, 1'b1);
            end
            if (d_wr) begin
                wr_cnt++;
                if (d_adr == 10'h3FF) bad_wr++;
                if (first_wr_k < 0) begin first_wr_k = k; wr_adr = d_adr; wr_dat = d_dat_o; end
            end
            if (d_mi) begin mi_k = k; break; end
        end
        check("d_first_wr_cycle", first_wr_k, 3);
        check("d_first_wr_value", {wr_adr, wr_dat}, {10'h0AA, 32'h0000_0001});
        check("d_wr_count", wr_cnt, 1);
        check("d_done_cycle", mi_k, 26);
        check("d_beyond_end_untouched", bad_wr, 0);
        repeat (3) @(negedge clk);
        check("d_done_holds", {d_mi, d_sb, d_er, d_wr, d_rd}, 5'b10000);

        check("rd_wr_never_both", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
